// File: rtl/reg_file_sb.sv
`timescale 1ns/1ps
// reg_file_sb: register file with two combinational read ports, a pending-write (busy) scoreboard
// and a hardware clear sweep after reset. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_dat_1,
    output logic              rd_busy_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_dat_2,
    output logic              rd_busy_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              run;
    logic              wr_ok;
    logic              rsv_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && sweep_cnt == ADDR_W'(DEPTH - 1))
            state_nxt = RUN;
    end

    always_comb begin
        run   = (state == RUN);
        ready = run;
    end

    // Entry 0 silently absorbs writes and reservations when it is hardwired to zero.
    always_comb begin
        wr_ok  = run && wr_en  && !(ZERO_REG && wr_addr  == '0);
        rsv_ok = run && rsv_en && !(ZERO_REG && rsv_addr == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sweep_cnt <= '0;
        else if (state == INIT)
            sweep_cnt <= sweep_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[sweep_cnt] <= '0;
        else if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

    // Reserve is applied after the release so a same-cycle reserve leaves the entry busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (wr_ok)
                busy[wr_addr] <= 1'b0;
            if (rsv_ok)
                busy[rsv_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rsv_err <= 1'b0;
        else
            rsv_err <= rsv_ok && busy[rsv_addr] && !(wr_ok && wr_addr == rsv_addr);
    end

    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W:0] res;
        res = {busy[addr], mem[addr]};
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && wr_addr == addr)
            res = {rsv_ok && rsv_addr == addr, wr_data};
`else
        res = {busy[addr], mem[addr]};
`endif
        if (!run || (ZERO_REG && addr == '0))
            res = '0;
        return res;
    endfunction

    always_comb {rd_busy_1, rd_dat_1} = read_port(rd_addr_1);
    always_comb {rd_busy_2, rd_dat_2} = read_port(rd_addr_2);

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read register file with a per-register pending-write scoreboard and a self-clearing initialisation sweep. It holds the datapath's architectural registers. Decode reads two operands and reserves a destination; writeback commits results and releases the reservation. Hazard detection uses the busy flags returned alongside each read. Contents are cleared by hardware after reset, not loaded from a memory file.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 0, 1 = entry 0 hardwired to zero (never written, never busy)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- ready  output  1  high once the init sweep is complete; reset value 0
- rd_addr_1  input  ADDR_W  read port 1 address
- rd_dat_1  output  DATA_W  read port 1 data, combinational
- rd_busy_1  output  1  entry at rd_addr_1 has a pending write
- rd_addr_2  input  ADDR_W  read port 2 address
- rd_dat_2  output  DATA_W  read port 2 data, combinational
- rd_busy_2  output  1  entry at rd_addr_2 has a pending write
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback address
- wr_data  input  DATA_W  writeback data, full width, no truncation
- rsv_en  input  1  reserve destination (set busy)
- rsv_addr  input  ADDR_W  reserved address
- rsv_err  output  1  registered one-cycle pulse: reservation of an already-busy entry; reset value 0

## Operation
- FSM states: INIT, RUN. Reset low forces INIT, sweep counter = 0, all busy bits = 0, ready = 0, rsv_err = 0.
- INIT: each posedge writes 0 to entry[counter] and increments the counter. After entry DEPTH-1 is written, the FSM goes to RUN and ready becomes 1.
- During INIT, wr_en and rsv_en are ignored, rd_dat_x = 0, and rd_busy_x = 0.
- RUN write: wr_en=1 stores wr_data into entry[wr_addr] and clears busy[wr_addr] at the posedge.
- RUN reserve: rsv_en=1 sets busy[rsv_addr] at the posedge. If busy[rsv_addr] was already 1, the entry stays busy and rsv_err pulses the next cycle.
- Same-cycle rsv_en and wr_en to the same address: the reserve wins, so busy ends at 1. This is not an error, because the write releases the old reservation.
- ZERO_REG=1 and address 0:
  - rd_dat = 0 and rd_busy = 0.
  - Writes are dropped.
  - Reservations are dropped and never raise rsv_err.
- Both read ports are independent and may name the same address.
- Reset asserted mid-operation aborts everything immediately. Any in-progress sweep restarts from 0 once reset releases.

## Timing
- Reads are combinational from the array and busy vector: zero latency.
- Write and reserve take effect at the posedge: visible to reads the following cycle, or the same cycle if forwarded (see Configuration).
- Init latency: reset deasserted, then posedges 1..DEPTH clear entries 0..DEPTH-1. ready is high after posedge DEPTH.
- rsv_err asserts one cycle after the offending rsv_en and lasts one cycle.

## Configuration
- REGFILE_BYPASS_EN defined: when wr_en=1 in RUN and wr_addr equals rd_addr_x, the following hold in the same cycle:
  - rd_dat_x = wr_data.
  - rd_busy_x = 0, unless rsv_en targets the same address in that cycle, in which case busy stays visible.
  - The ZERO_REG rule overrides forwarding.
- REGFILE_BYPASS_EN undefined: reads always return the registered array and busy state. A same-cycle write is visible only from the next cycle.

## Test plan
- Init sweep (DATA_W=16, ADDR_W=2): release reset with the array pre-filled with X.
  - ready is 0 for 4 posedges and 1 after the 4th.
  - All four entries then read 0x0000 with busy 0.
- Write/read: wr 0xBEEF to r2, then rd_addr_1=2 next cycle.
  - rd_dat_1=0xBEEF.
  - Same-cycle read shows 0xBEEF only with REGFILE_BYPASS_EN; otherwise it shows 0x0000.
- Scoreboard: rsv r3, then rd_busy_2=1 at rd_addr_2=3 next cycle. Then wr 0x1234 to r3, after which busy is 0 and data is 0x1234.
- Conflict: rsv r1 twice in consecutive cycles. rsv_err pulses exactly once, one cycle after the second reserve. Same-cycle rsv+wr to r1 leaves busy=1 with no rsv_err.
- ZERO_REG=1:
  - wr 0xFFFF to r0 and rsv r0, then r0 reads 0x0000 with busy 0 and rsv_err 0.
  - The bypass path also returns 0.
- Mid-sweep reset: assert reset at posedge 2 of INIT. ready drops to 0 and the busy bits clear. After release, ready rises exactly 4 posedges later.
